axi_lite_write_slave: RTL and testbench
=======================================

# axi_lite_write_slave

AXI4-Lite write-channel front end for the adder peripheral. Accepts AW and W beats in any order, checks alignment, range and strobes, then drives a single-cycle write strobe with a word index and data into the register file's write channel (`i_addr_wc`, `i_data_wc`, `i_en_amba_write`). It returns one B response per transaction. It sits directly upstream of `regfile`; its `o_*` outputs connect one-to-one to the regfile write inputs.

## Interface
Parameters:
- `NUM_REGS`, 4: number of 32-bit registers decoded; valid byte addresses are 0 .. 4*NUM_REGS-4.

Ports:
- `ACLK`  in  1  clock; all logic on rising edge.
- `ARST`  in  1  reset; asynchronous, active-high.
- `AWADDR`  in  32  write byte address.
- `AWVALID`  in  1  address valid.
- `AWREADY`  out  1  address accepted.
- `WDATA`  in  32  write data.
- `WSTRB`  in  4  byte strobes.
- `WVALID`  in  1  data valid.
- `WREADY`  out  1  data accepted.
- `BRESP`  out  2  response: 2'b00 OKAY, 2'b10 SLVERR.
- `BVALID`  out  1  response valid.
- `BREADY`  in  1  master accepts response.
- `o_addr_wc`  out  32  word index (`AWADDR >> 2`), zero-extended.
- `o_data_wc`  out  32  write data to regfile.
- `o_en_amba_write`  out  1  one-cycle write strobe to regfile.

## Operation
- Two independent one-deep holding slots: AW slot (address) and W slot (data + strobe).
- `AWREADY` = AW slot empty AND state == IDLE. `WREADY` = W slot empty AND state == IDLE. Both are combinational from registered state.
- Handshake:
  - A beat is captured at the edge where VALID && READY.
  - AW and W may arrive in the same cycle or in either order.
  - The slot that fills first holds until its partner arrives. Its READY stays low.
- FSM:
  - IDLE → WRITE on the edge at which both slots become full.
  - WRITE → RESP unconditionally after one cycle.
  - RESP → IDLE on the edge where BVALID && BREADY. Both slots clear on that edge.
- Error check, evaluated from the held values in WRITE:
  - err = `AWADDR[1:0] != 0` OR `AWADDR >= 4*NUM_REGS` OR `WSTRB != 4'hF`.
- In WRITE:
  - `o_en_amba_write` = !err.
  - `o_addr_wc` = `AWADDR[31:2]` zero-extended.
  - `o_data_wc` = `WDATA`.
  - The err flag is registered for the response.
- In RESP: `BVALID` = 1. `BRESP` = err ? 2'b10 : 2'b00. Both are held stable until BREADY.
- Outside WRITE, `o_en_amba_write` = 0. `o_addr_wc` and `o_data_wc` hold their last values.
- Reset:
  - All slots empty, state IDLE.
  - `BVALID`, `BRESP`, `o_en_amba_write`, `o_addr_wc` and `o_data_wc` are all 0.
  - `AWREADY` and `WREADY` are 0 while `ARST` is high and 1 in the first cycle after deassertion.
- Reset mid-transaction drops it: no write strobe, no B response.

## Timing
- Latency: AW and W accepted together at edge N → `o_en_amba_write` high during cycle N+1 → `BVALID` high during cycle N+2.
- With BREADY=1 in cycle N+2, READYs are high again in cycle N+3. Peak throughput is one write per 3 cycles.
- Split arrival: W at edge N, AW at edge N+k → strobe in cycle N+k+1.
- BREADY low stalls in RESP indefinitely. No new AW or W is accepted while stalled.
- Exactly one strobe at most, and exactly one B response, per AW/W pair.

## Structure
- Shared package `amba_pkg`:
  - `resp_t` enum (RESP_OKAY=2'b00, RESP_SLVERR=2'b10).
  - `wr_state_t` enum (IDLE, WRITE, RESP).
  - Localparam `FULL_STRB = 4'hF`.
- One natural sub-module `axi_hold_slot`:
  - Parameterised width; one-deep register with full flag.
  - Has load-on-handshake and clear inputs.
  - Instantiated twice, once for AW (32 bits) and once for W (36 bits).
- FSM and error decode live in the top module.

## Test plan
- Aligned write, AW and W in the same cycle: AWADDR=0x8, WDATA=0xDEADBEEF, WSTRB=F, BREADY=1 → strobe one cycle later with o_addr_wc=2, o_data_wc=0xDEADBEEF; next cycle BVALID=1, BRESP=00.
- W three cycles before AW: WDATA=0x12345678, then AWADDR=0x4 → WREADY low while waiting; strobe with o_addr_wc=1 one cycle after AW capture; BRESP=00.
- Errors, each with BVALID=1 and BRESP=10 and no strobe:
  - AWADDR=0x10 (out of range);
  - AWADDR=0x6 (misaligned);
  - WSTRB=4'h3 (partial strobe).
- BREADY held low 5 cycles after BVALID → BVALID and BRESP stable; AWREADY=WREADY=0 throughout; one response completes when BREADY rises.
- ARST asserted in the WRITE/RESP cycle of a transaction to 0xC → outputs 0 immediately; no strobe after release; next write to 0x0 completes normally.
- 100 random back-to-back transactions against a scoreboard regfile model → every valid write is mirrored exactly once and response codes match the error rule.

Source files
------------

// File: rtl/amba_pkg.sv
// Shared AMBA types for the adder peripheral bus front ends.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package amba_pkg;

    // B-channel response codes.
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    // Write-side transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        RESP  = 2'b10
    } wr_state_t;

    // A write is only legal when every byte lane is enabled.
    localparam logic [3:0] FULL_STRB = 4'hF;

    // Byte address to 32-bit word index, zero-extended.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage

// File: rtl/axi_hold_slot.sv
// One-deep holding register with a full flag for a single AXI channel beat.
// Latency: captured value visible on q the cycle after the load edge.
// Backpressure: owner deasserts READY while full; clear wins over load.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   load       capture d (asserted on the VALID && READY handshake)
//   clear      empty the slot (transaction retired)
//   d / q      beat payload in / held payload out
//   full       slot holds a beat
module axi_hold_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            full <= 1'b0;
        end else if (clear) begin
            // Payload is left in place; only the full flag matters once cleared.
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write front end: pairs AW and W beats, validates them, strobes the regfile.
// Latency: pair complete at edge N -> write strobe in cycle N+1 -> BVALID in cycle N+2.
// Backpressure: AWREADY/WREADY low while a slot is full or a transaction is in flight; BREADY low stalls in RESP.
//
// Ports:
//   ACLK, ARST                    clock and asynchronous active-high reset
//   AWADDR/AWVALID/AWREADY        write address channel
//   WDATA/WSTRB/WVALID/WREADY     write data channel
//   BRESP/BVALID/BREADY           write response channel
//   o_addr_wc, o_data_wc          word index and data for the regfile write port
//   o_en_amba_write               single-cycle regfile write enable
module axi_lite_write_slave
    import amba_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [31:0] o_addr_wc,
    output logic [31:0] o_data_wc,
    output logic        o_en_amba_write
);

    // First byte address past the decoded register window.
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * NUM_REGS);

    wr_state_t   state_q;
    wr_state_t   state_d;

    logic        aw_full;
    logic [31:0] aw_q;
    logic        aw_load;

    logic        w_full;
    logic [35:0] w_q;
    logic        w_load;
    logic [31:0] w_data;
    logic [3:0]  w_strb;

    logic        slot_clear;
    logic        err;
    logic        err_q;
    logic [31:0] addr_last_q;
    logic [31:0] data_last_q;
    resp_t       bresp_d;

    // ------------------------------------------------------------------
    // Channel handshakes. READY is gated by ARST so nothing is offered
    // while the block is held in reset.
    // ------------------------------------------------------------------
    assign AWREADY    = !ARST && !aw_full && (state_q == IDLE);
    assign WREADY     = !ARST && !w_full  && (state_q == IDLE);
    assign aw_load    = AWVALID && AWREADY;
    assign w_load     = WVALID  && WREADY;
    assign slot_clear = (state_q == RESP) && BREADY;

    axi_hold_slot #(
        .WIDTH (32)
    ) u_aw_slot (
        .clk   (ACLK),
        .rst   (ARST),
        .load  (aw_load),
        .clear (slot_clear),
        .d     (AWADDR),
        .q     (aw_q),
        .full  (aw_full)
    );

    axi_hold_slot #(
        .WIDTH (36)
    ) u_w_slot (
        .clk   (ACLK),
        .rst   (ARST),
        .load  (w_load),
        .clear (slot_clear),
        .d     ({WSTRB, WDATA}),
        .q     (w_q),
        .full  (w_full)
    );

    assign w_strb = w_q[35:32];
    assign w_data = w_q[31:0];

    // Decode from the held beats; only meaningful while both slots are full.
    assign err = (aw_q[1:0] != 2'b00) || (aw_q >= ADDR_LIMIT) || (w_strb != FULL_STRB);

    // ------------------------------------------------------------------
    // Sequencer state register.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and channel outputs.
    always_comb begin
        state_d         = state_q;
        BVALID          = 1'b0;
        bresp_d         = RESP_OKAY;
        o_en_amba_write = 1'b0;
        o_addr_wc       = addr_last_q;
        o_data_wc       = data_last_q;
        case (state_q)
            IDLE: begin
                // Each slot is either already full or filling on this edge.
                if ((aw_full || aw_load) && (w_full || w_load)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                o_en_amba_write = !err;
                o_addr_wc       = word_index(aw_q);
                o_data_wc       = w_data;
                state_d         = RESP;
            end
            RESP: begin
                BVALID  = 1'b1;
                bresp_d = err_q ? RESP_SLVERR : RESP_OKAY;
                if (BREADY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign BRESP = bresp_d;

    // ------------------------------------------------------------------
    // Error flag for the response and last-written address/data, which
    // the regfile port keeps presenting between writes.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            err_q       <= 1'b0;
            addr_last_q <= '0;
            data_last_q <= '0;
        end else if (state_q == WRITE) begin
            err_q       <= err;
            addr_last_q <= word_index(aw_q);
            data_last_q <= w_data;
        end
    end

endmodule

// File: tb/tb_axi_lite_write_slave.sv
module tb_axi_lite_write_slave;

    localparam int NUM_REGS = 4;

    logic        ACLK;
    logic        ARST;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] o_addr_wc;
    logic [31:0] o_data_wc;
    logic        o_en_amba_write;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observed regfile contents (from the write strobe) and the bench's own model.
    logic [31:0] mirror    [NUM_REGS];
    logic [31:0] model_mem [NUM_REGS];
    int          strobe_cnt = 0;
    int          bad_strobe = 0;

    axi_lite_write_slave #(
        .NUM_REGS (NUM_REGS)
    ) dut (
        .ACLK            (ACLK),
        .ARST            (ARST),
        .AWADDR          (AWADDR),
        .AWVALID         (AWVALID),
        .AWREADY         (AWREADY),
        .WDATA           (WDATA),
        .WSTRB           (WSTRB),
        .WVALID          (WVALID),
        .WREADY          (WREADY),
        .BRESP           (BRESP),
        .BVALID          (BVALID),
        .BREADY          (BREADY),
        .o_addr_wc       (o_addr_wc),
        .o_data_wc       (o_data_wc),
        .o_en_amba_write (o_en_amba_write)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Strobe monitor on the falling edge, mid-cycle.
    always @(negedge ACLK) begin
        if (o_en_amba_write === 1'b1) begin
            strobe_cnt++;
            if (o_addr_wc < NUM_REGS) mirror[o_addr_wc[1:0]] = o_data_wc;
            else bad_strobe++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Present one AW/W pair. gap > 0: W leads AW by gap cycles; gap < 0: AW leads.
    // Returns at #1 after the edge on which the second beat was captured.
    task automatic drive_pair(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int gap, output bit ok);
        int aw_start;
        int w_start;
        bit aw_done;
        bit w_done;
        bit aw_hs;
        bit w_hs;
        aw_start = (gap > 0) ? gap : 0;
        w_start  = (gap < 0) ? -gap : 0;
        aw_done  = 0;
        w_done   = 0;
        ok       = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == aw_start && !aw_done) begin AWVALID = 1'b1; AWADDR = addr; end
            if (cyc == w_start && !w_done) begin WVALID = 1'b1; WDATA = data; WSTRB = strb; end
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            tick();
            if (aw_hs) begin aw_done = 1; AWVALID = 1'b0; end
            if (w_hs)  begin w_done  = 1; WVALID  = 1'b0; end
            if (aw_done && w_done) begin ok = 1; break; end
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
    endtask

    function automatic bit exp_err(input logic [31:0] addr, input logic [3:0] strb);
        return (addr[1:0] != 2'b00) || (addr >= 32'(4 * NUM_REGS)) || (strb != 4'hF);
    endfunction

    task automatic test_reset();
        ARST = 1'b1;
        tick(); tick();
        n_cmp++; if (AWREADY !== 1'b0) begin n_fail++; $display("FAIL rst_awready: got %b want 0", AWREADY); end
        n_cmp++; if (WREADY !== 1'b0) begin n_fail++; $display("FAIL rst_wready: got %b want 0", WREADY); end
        n_cmp++; if (BVALID !== 1'b0 || BRESP !== 2'b00) begin n_fail++; $display("FAIL rst_b: got %b/%b want 0/00", BVALID, BRESP); end
        n_cmp++; if (o_en_amba_write !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %b want 0", o_en_amba_write); end
        n_cmp++; if (o_addr_wc !== 32'h0 || o_data_wc !== 32'h0) begin n_fail++; $display("FAIL rst_wc: got %h/%h want 0/0", o_addr_wc, o_data_wc); end
        ARST = 1'b0;
        #1;
        n_cmp++; if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin n_fail++; $display("FAIL rst_release_rdy: got %b%b want 11", AWREADY, WREADY); end
        tick();
    endtask

    task automatic test_aligned();
        bit ok;
        int s0;
        s0 = strobe_cnt;
        drive_pair(32'h8, 32'hDEADBEEF, 4'hF, 0, ok);
        model_mem[2] = 32'hDEADBEEF;
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL al_handshake: got timeout want accepted"); end
        n_cmp++; if (o_en_amba_write !== 1'b1) begin n_fail++; $display("FAIL al_strobe: got %b want 1", o_en_amba_write); end
        n_cmp++; if (o_addr_wc !== 32'd2) begin n_fail++; $display("FAIL al_addr: got %h want 2", o_addr_wc); end
        n_cmp++; if (o_data_wc !== 32'hDEADBEEF) begin n_fail++; $display("FAIL al_data: got %h want deadbeef", o_data_wc); end
        n_cmp++; if (BVALID !== 1'b0 || AWREADY !== 1'b0) begin n_fail++; $display("FAIL al_write_cycle: got bvalid=%b awready=%b want 0/0", BVALID, AWREADY); end
        tick();
        n_cmp++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_fail++; $display("FAIL al_resp: got %b/%b want 1/00", BVALID, BRESP); end
        n_cmp++; if (o_en_amba_write !== 1'b0 || o_addr_wc !== 32'd2) begin n_fail++; $display("FAIL al_hold: got en=%b addr=%h want 0/2", o_en_amba_write, o_addr_wc); end
        tick();
        n_cmp++; if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin n_fail++; $display("FAIL al_ready_again: got b=%b rdy=%b%b want 0/11", BVALID, AWREADY, WREADY); end
        n_cmp++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL al_strobe_count: got %0d want 1", strobe_cnt - s0); end
    endtask

    task automatic test_w_first();
        int s0;
        s0 = strobe_cnt;
        WVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF;
        tick();
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (WREADY !== 1'b0 || AWREADY !== 1'b1) begin n_fail++; $display("FAIL wf_wait_rdy[%0d]: got w=%b aw=%b want 0/1", i, WREADY, AWREADY); end
            n_cmp++; if (o_en_amba_write !== 1'b0) begin n_fail++; $display("FAIL wf_wait_en[%0d]: got %b want 0", i, o_en_amba_write); end
            if (i == 2) begin AWVALID = 1'b1; AWADDR = 32'h4; end
            tick();
        end
        AWVALID = 1'b0;
        model_mem[1] = 32'h12345678;
        n_cmp++; if (o_en_amba_write !== 1'b1 || o_addr_wc !== 32'd1 || o_data_wc !== 32'h12345678) begin
            n_fail++; $display("FAIL wf_strobe: got en=%b addr=%h data=%h want 1/1/12345678", o_en_amba_write, o_addr_wc, o_data_wc); end
        tick();
        n_cmp++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_fail++; $display("FAIL wf_resp: got %b/%b want 1/00", BVALID, BRESP); end
        tick();
        n_cmp++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL wf_strobe_count: got %0d want 1", strobe_cnt - s0); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        logic [3:0]  strbs [3];
        bit ok;
        int s0;
        addrs[0] = 32'h10; strbs[0] = 4'hF;
        addrs[1] = 32'h6;  strbs[1] = 4'hF;
        addrs[2] = 32'h4;  strbs[2] = 4'h3;
        for (int i = 0; i < 3; i++) begin
            s0 = strobe_cnt;
            drive_pair(addrs[i], 32'hBAD0_0000 + i, strbs[i], 0, ok);
            n_cmp++; if (!ok || o_en_amba_write !== 1'b0) begin n_fail++; $display("FAIL err_nostrobe[%0d]: got ok=%b en=%b want 1/0", i, ok, o_en_amba_write); end
            tick();
            n_cmp++; if (BVALID !== 1'b1 || BRESP !== 2'b10) begin n_fail++; $display("FAIL err_resp[%0d]: got %b/%b want 1/10", i, BVALID, BRESP); end
            tick();
            n_cmp++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL err_strobe_count[%0d]: got %0d want 0", i, strobe_cnt - s0); end
        end
    endtask

    task automatic test_bready_stall();
        bit ok;
        int s0;
        s0 = strobe_cnt;
        BREADY = 1'b0;
        drive_pair(32'h4, 32'hCAFEF00D, 4'hF, 0, ok);
        model_mem[1] = 32'hCAFEF00D;
        tick();
        // Offer a new pair during the stall; it must not be taken.
        AWVALID = 1'b1; AWADDR = 32'h0; WVALID = 1'b1; WDATA = 32'h0; WSTRB = 4'hF;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_fail++; $display("FAIL stall_b[%0d]: got %b/%b want 1/00", i, BVALID, BRESP); end
            n_cmp++; if (AWREADY !== 1'b0 || WREADY !== 1'b0) begin n_fail++; $display("FAIL stall_rdy[%0d]: got %b%b want 00", i, AWREADY, WREADY); end
            tick();
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        BREADY = 1'b1;
        tick();
        n_cmp++; if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin n_fail++; $display("FAIL stall_release: got b=%b aw=%b want 0/1", BVALID, AWREADY); end
        n_cmp++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL stall_strobe_count: got %0d want 1", strobe_cnt - s0); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int s0;
        s0 = strobe_cnt;
        drive_pair(32'hC, 32'h0BADF00D, 4'hF, 0, ok);
        ARST = 1'b1;
        #1;
        n_cmp++; if (o_en_amba_write !== 1'b0 || BVALID !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got en=%b b=%b want 0/0", o_en_amba_write, BVALID); end
        n_cmp++; if (o_addr_wc !== 32'h0 || o_data_wc !== 32'h0) begin n_fail++; $display("FAIL midrst_wc: got %h/%h want 0/0", o_addr_wc, o_data_wc); end
        tick();
        ARST = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (strobe_cnt - s0 !== 0 || BVALID !== 1'b0) begin n_fail++; $display("FAIL midrst_dropped: got strobes=%0d b=%b want 0/0", strobe_cnt - s0, BVALID); end
        drive_pair(32'h0, 32'h00C0FFEE, 4'hF, -1, ok);
        model_mem[0] = 32'h00C0FFEE;
        n_cmp++; if (!ok || o_en_amba_write !== 1'b1 || o_addr_wc !== 32'd0 || o_data_wc !== 32'h00C0FFEE) begin
            n_fail++; $display("FAIL midrst_next: got ok=%b en=%b addr=%h data=%h want 1/1/0/00c0ffee", ok, o_en_amba_write, o_addr_wc, o_data_wc); end
        tick();
        n_cmp++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_fail++; $display("FAIL midrst_resp: got %b/%b want 1/00", BVALID, BRESP); end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int s0;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int gap;
        bit e;
        for (int t = 0; t < 100; t++) begin
            addr = 32'($urandom_range(0, 19));
            if ($urandom_range(0, 9) == 0) addr = $urandom();
            data = $urandom();
            strb = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            gap  = int'($urandom_range(0, 4)) - 2;
            e    = exp_err(addr, strb);
            s0   = strobe_cnt;
            drive_pair(addr, data, strb, gap, ok);
            if (!e) model_mem[addr[3:2]] = data;
            n_cmp++; if (!ok || o_en_amba_write !== !e) begin n_fail++; $display("FAIL b2b_strobe[%0d]: addr=%h strb=%h got ok=%b en=%b want 1/%b", t, addr, strb, ok, o_en_amba_write, !e); end
            tick();
            n_cmp++; if (BVALID !== 1'b1 || BRESP !== (e ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL b2b_resp[%0d]: addr=%h got %b/%b want 1/%b", t, addr, BVALID, BRESP, e ? 2'b10 : 2'b00); end
            tick();
            n_cmp++; if (strobe_cnt - s0 !== (e ? 0 : 1)) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want %0d", t, strobe_cnt - s0, e ? 0 : 1); end
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            n_cmp++; if (mirror[r] !== model_mem[r]) begin n_fail++; $display("FAIL b2b_mirror[%0d]: got %h want %h", r, mirror[r], model_mem[r]); end
        end
        n_cmp++; if (bad_strobe !== 0) begin n_fail++; $display("FAIL b2b_bad_strobe: got %0d want 0", bad_strobe); end
    endtask

    initial begin
        for (int r = 0; r < NUM_REGS; r++) begin
            mirror[r]    = 32'h0;
            model_mem[r] = 32'h0;
        end
        ARST    = 1'b1;
        AWADDR  = 32'h0;
        AWVALID = 1'b0;
        WDATA   = 32'h0;
        WSTRB   = 4'h0;
        WVALID  = 1'b0;
        BREADY  = 1'b1;
        test_reset();
        test_aligned();
        test_w_first();
        test_errors();
        test_bready_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
